// File: rtl/status_reg.sv
// status_reg: 6502 processor status register with flag updates, branch conditions and IRQ mask
module status_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_Y,
    input  logic       alu_carry_out,
    input  logic       alu_overflow,
    input  logic       flag_update,
    input  logic [3:0] flag_mask,
    input  logic       bit_test,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] data_in,
    input  logic       irq_entry,
    input  logic       push_brk,
    input  logic       sync,
    input  logic [2:0] branch_sel,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       carry_flag,
    output logic       decimal_flag,
    output logic       branch_taken,
    output logic       irq_masked
);
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLC  = 3'd1,
        OP_SEC  = 3'd2,
        OP_CLI  = 3'd3,
        OP_SEI  = 3'd4,
        OP_CLD  = 3'd5,
        OP_SED  = 3'd6,
        OP_CLV  = 3'd7
    } flag_op_t;

    logic n, v, d, i, z, c;
    logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
    logic upd_n, upd_v, upd_z, upd_c;
    flag_op_t op;

    assign op = flag_op_t'(flag_op);

    // next flag values; p_load wins, flag_op beats the ALU on C/V, irq_entry beats CLI
    always_comb begin
        upd_n = flag_update && flag_mask[3];
        upd_v = flag_update && flag_mask[2];
        upd_z = flag_update && flag_mask[1];
        upd_c = flag_update && flag_mask[0] && !bit_test;
        n_nx  = p_load ? data_in[7] : upd_n ? (bit_test ? data_in[7] : alu_Y[7]) : n;
        v_nx  = p_load ? data_in[6] : (op == OP_CLV) ? 1'b0
              : upd_v ? (bit_test ? data_in[6] : alu_overflow) : v;
        d_nx  = p_load ? data_in[3] : (op == OP_CLD) ? 1'b0 : (op == OP_SED) ? 1'b1 : d;
        i_nx  = p_load ? data_in[2] : (irq_entry || op == OP_SEI) ? 1'b1
              : (op == OP_CLI) ? 1'b0 : i;
        z_nx  = p_load ? data_in[1] : upd_z ? (alu_Y == 8'h00) : z;
        c_nx  = p_load ? data_in[0] : (op == OP_CLC) ? 1'b0 : (op == OP_SEC) ? 1'b1
              : upd_c ? alu_carry_out : c;
    end

    // flag register; irq_masked samples the pre-update I on opcode fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {n, v, d, i, z, c} <= 6'b000100;
            irq_masked         <= 1'b1;
        end else begin
            {n, v, d, i, z, c} <= {n_nx, v_nx, d_nx, i_nx, z_nx, c_nx};
            if (sync) irq_masked <= i;
        end
    end

    // branch condition: sel[2:1] picks N/V/C/Z, sel[0] picks set vs clear
    always_comb begin
        branch_taken = (branch_sel[2:1] == 2'd0) ? (n == branch_sel[0])
                     : (branch_sel[2:1] == 2'd1) ? (v == branch_sel[0])
                     : (branch_sel[2:1] == 2'd2) ? (c == branch_sel[0])
                     : (z == branch_sel[0]);
    end

    assign p_out        = {n, v, 1'b1, 1'b0, d, i, z, c};
    assign p_push       = {n, v, 1'b1, push_brk, d, i, z, c};
    assign carry_flag   = c;
    assign decimal_flag = d;
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: randomized and directed checks of status_reg against a byte-level P model
module tb_status_reg;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_Y;
    logic       alu_carry_out, alu_overflow, flag_update, bit_test, p_load, irq_entry, push_brk, sync;
    logic [3:0] flag_mask;
    logic [2:0] flag_op, branch_sel;
    logic [7:0] data_in;
    logic [7:0] p_out, p_push;
    logic       carry_flag, decimal_flag, branch_taken, irq_masked;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] mp;
    logic       mim;

    status_reg dut (
        .clk(clk), .reset(reset), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out),
        .alu_overflow(alu_overflow), .flag_update(flag_update), .flag_mask(flag_mask),
        .bit_test(bit_test), .flag_op(flag_op), .p_load(p_load), .data_in(data_in),
        .irq_entry(irq_entry), .push_brk(push_brk), .sync(sync), .branch_sel(branch_sel),
        .p_out(p_out), .p_push(p_push), .carry_flag(carry_flag), .decimal_flag(decimal_flag),
        .branch_taken(branch_taken), .irq_masked(irq_masked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic model_branch(input logic [2:0] sel);
        case (sel)
            3'd0: return !mp[7];
            3'd1: return mp[7];
            3'd2: return !mp[6];
            3'd3: return mp[6];
            3'd4: return !mp[0];
            3'd5: return mp[0];
            3'd6: return !mp[1];
            default: return mp[1];
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".p_out"}, p_out, mp);
        check({tag, ".p_push"}, p_push, mp | {3'b000, push_brk, 4'h0});
        check({tag, ".carry"}, {7'd0, carry_flag}, {7'd0, mp[0]});
        check({tag, ".decimal"}, {7'd0, decimal_flag}, {7'd0, mp[3]});
        check({tag, ".branch"}, {7'd0, branch_taken}, {7'd0, model_branch(branch_sel)});
        check({tag, ".irq_masked"}, {7'd0, irq_masked}, {7'd0, mim});
    endtask

    // apply the writes in rising priority order so later ones simply overwrite
    task automatic model_edge();
        logic [7:0] q;
        q = mp;
        if (flag_update) begin
            if (flag_mask[3]) q[7] = bit_test ? data_in[7] : alu_Y[7];
            if (flag_mask[2]) q[6] = bit_test ? data_in[6] : alu_overflow;
            if (flag_mask[1]) q[1] = (alu_Y == 8'h00);
            if (flag_mask[0] && !bit_test) q[0] = alu_carry_out;
        end
        case (flag_op)
            3'd1: q[0] = 1'b0;
            3'd2: q[0] = 1'b1;
            3'd3: q[2] = 1'b0;
            3'd4: q[2] = 1'b1;
            3'd5: q[3] = 1'b0;
            3'd6: q[3] = 1'b1;
            3'd7: q[6] = 1'b0;
            default: ;
        endcase
        if (irq_entry) q[2] = 1'b1;
        if (p_load) q = {data_in[7:6], 2'b10, data_in[3:0]};
        if (sync) mim = mp[2];
        mp = q;
    endtask

    task automatic clear();
        alu_Y = 0; alu_carry_out = 0; alu_overflow = 0; flag_update = 0; flag_mask = 0;
        bit_test = 0; flag_op = 0; p_load = 0; data_in = 0; irq_entry = 0; push_brk = 0;
        sync = 0; branch_sel = 0;
    endtask

    task automatic cycle(input string tag);
        #1 check_outputs(tag);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 mp = 8'h24; mim = 1'b1;
        check({tag, ".rst_p_out"}, p_out, 8'h24);
        check({tag, ".rst_irq"}, {7'd0, irq_masked}, 8'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear();
        @(negedge clk);
        #1 mp = 8'h24; mim = 1'b1;
        check("reset.p_out", p_out, 8'h24);
        check("reset.p_push", p_push, 8'h24);
        check("reset.bpl", {7'd0, branch_taken}, 8'd1);
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        flag_op = 3'd2;
        cycle("sec");
        #1 check("sec.p_out", p_out, 8'h25);
        do_reset("midop");
        clear();
        cycle("after_rst");
        check("after_rst.carry", {7'd0, carry_flag}, 8'd0);

        alu_Y = 8'h00; alu_carry_out = 1; alu_overflow = 1; flag_mask = 4'hF; flag_update = 1;
        cycle("alu");
        clear();
        #1 check("alu.p_out", p_out, 8'h67);
        branch_sel = 3'd7; #1 check("alu.beq", {7'd0, branch_taken}, 8'd1);
        branch_sel = 3'd5; #1 check("alu.bcs", {7'd0, branch_taken}, 8'd1);
        branch_sel = 3'd3; #1 check("alu.bvs", {7'd0, branch_taken}, 8'd1);
        @(negedge clk);
        alu_Y = 8'h80; alu_carry_out = 1; flag_mask = 4'b0001; flag_update = 1;
        cycle("alu_c");
        clear();
        #1 check("alu_c.p_out", p_out, 8'h67);

        data_in = 8'hC0; alu_Y = 8'h00; bit_test = 1; flag_mask = 4'b1110; flag_update = 1;
        cycle("bit");
        clear();
        #1 check("bit.p_out", p_out, 8'hE7);

        @(negedge clk);
        p_load = 1; data_in = 8'hFF; flag_op = 3'd1;
        cycle("plp_clc");
        clear();
        #1 check("plp_clc.p_out", p_out, 8'hEF);
        @(negedge clk);
        flag_update = 1; flag_mask = 4'b0001; alu_carry_out = 1; flag_op = 3'd1;
        cycle("upd_clc");
        clear();
        #1 check("upd_clc.carry", {7'd0, carry_flag}, 8'd0);
        @(negedge clk);
        flag_op = 3'd3;
        cycle("cli");
        clear();
        #1 check("cli.p_out", p_out, 8'hEA);
        @(negedge clk);
        irq_entry = 1; flag_op = 3'd3;
        cycle("irq_cli");
        clear();
        #1 check("irq_cli.p_out", p_out, 8'hEE);

        @(negedge clk);
        sync = 1;
        cycle("sync_i1");
        flag_op = 3'd3; sync = 1;
        cycle("cli_sync");
        clear();
        #1 check("cli_sync.irq", {7'd0, irq_masked}, 8'd1);
        @(negedge clk);
        cycle("idle1");
        cycle("idle2");
        sync = 1;
        cycle("sync2");
        clear();
        #1 check("sync2.irq", {7'd0, irq_masked}, 8'd0);

        @(negedge clk);
        do_reset("push");
        push_brk = 1;
        #1 check("push.p_push", p_push, 8'h34);
        check("push.p_out", p_out, 8'h24);
        p_load = 1; data_in = 8'h30;
        cycle("plp30");
        clear();
        #1 check("plp30.p_out", p_out, 8'h20);
        @(negedge clk);

        for (int k = 0; k < 3000; k++) begin
            alu_Y = 8'($urandom); alu_carry_out = 1'($urandom); alu_overflow = 1'($urandom);
            flag_update = ($urandom_range(0, 2) == 0); flag_mask = 4'($urandom);
            bit_test = ($urandom_range(0, 3) == 0); data_in = 8'($urandom);
            flag_op = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'd0;
            p_load = ($urandom_range(0, 9) == 0); irq_entry = ($urandom_range(0, 7) == 0);
            push_brk = 1'($urandom); sync = 1'($urandom); branch_sel = 3'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
